// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC generator plus the F/D pipeline register.
//
// Next fetch PC priority: execute redirect, stall / I-cache miss hold,
// static-predictor target, PC+4. The F/D register is flushed on a redirect,
// holds on a stall, takes a bubble on an I-cache miss and otherwise captures
// the fetched instruction.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   instr_f           instruction word from the I-cache at PC_f
//   instr_valid_f     I-cache hit, instr_f valid this cycle
//   predict_taken_f   static predictor says the instruction at PC_f is taken
//   branch_target_f   predictor target for the instruction at PC_f
//   stall_d           hold the PC and the decode register
//   redirect_e        execute-stage refetch request
//   redirect_pc_e     correct next PC from execute
//   PC_f              current fetch address
//   instr_d, PC_d, PCPlus4_d, predict_taken_d, valid_d   decode-stage outputs
//
// Optional feature (define BRANCH_STATS_EN):
//   predict_cnt       saturating count of cycles where the predicted target is taken
//   redirect_cnt      saturating count of redirect_e cycles
module fetch_pc_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr_f,
  input  logic                  instr_valid_f,
  input  logic                  predict_taken_f,
  input  logic [DATA_WIDTH-1:0] branch_target_f,
  input  logic                  stall_d,
  input  logic                  redirect_e,
  input  logic [DATA_WIDTH-1:0] redirect_pc_e,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] PC_d,
  output logic [DATA_WIDTH-1:0] PCPlus4_d,
  output logic                  predict_taken_d,
`ifdef BRANCH_STATS_EN
  output logic [31:0]           predict_cnt,
  output logic [31:0]           redirect_cnt,
`endif
  output logic                  valid_d
);

  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] dec_instr_q, dec_instr_d;
  logic [DATA_WIDTH-1:0] dec_pc_q, dec_pc_d;
  logic [DATA_WIDTH-1:0] dec_pc4_q, dec_pc4_d;
  logic                  dec_pred_q, dec_pred_d;
  logic                  dec_valid_q, dec_valid_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  hold_pc;
  logic                  use_pred;

  assign pc_plus4 = pc_f_q + DATA_WIDTH'(4);
  // A miss also holds the PC, so a prediction made on a miss cycle is dropped.
  assign hold_pc  = stall_d | ~instr_valid_f;
  assign use_pred = ~redirect_e & ~hold_pc & predict_taken_f;

  always_comb begin
    pc_f_d = pc_plus4;
    if (redirect_e) begin
      pc_f_d = redirect_pc_e;
    end else if (hold_pc) begin
      pc_f_d = pc_f_q;
    end else if (predict_taken_f) begin
      pc_f_d = branch_target_f;
    end
  end

  always_comb begin
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    dec_pc4_d   = dec_pc4_q;
    dec_pred_d  = dec_pred_q;
    dec_valid_d = dec_valid_q;
    if (redirect_e) begin
      // Flush wins over stall; PC fields are meaningless but driven to zero.
      dec_instr_d = NOP_INSTR;
      dec_pc_d    = '0;
      dec_pc4_d   = '0;
      dec_pred_d  = 1'b0;
      dec_valid_d = 1'b0;
    end else if (stall_d) begin
      // hold everything
    end else if (!instr_valid_f) begin
      // Bubble: PC fields keep their last value.
      dec_instr_d = NOP_INSTR;
      dec_pred_d  = 1'b0;
      dec_valid_d = 1'b0;
    end else begin
      dec_instr_d = instr_f;
      dec_pc_d    = pc_f_q;
      dec_pc4_d   = pc_plus4;
      dec_pred_d  = predict_taken_f;
      dec_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q      <= RESET_PC;
      dec_instr_q <= NOP_INSTR;
      dec_pc_q    <= '0;
      dec_pc4_q   <= '0;
      dec_pred_q  <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      dec_pc4_q   <= dec_pc4_d;
      dec_pred_q  <= dec_pred_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign PC_f            = pc_f_q;
  assign instr_d         = dec_instr_q;
  assign PC_d            = dec_pc_q;
  assign PCPlus4_d       = dec_pc4_q;
  assign predict_taken_d = dec_pred_q;
  assign valid_d         = dec_valid_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] predict_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predict_cnt_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (use_pred && predict_cnt_q != '1) begin
        predict_cnt_q <= predict_cnt_q + 32'd1;
      end
      if (redirect_e && redirect_cnt_q != '1) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign predict_cnt  = predict_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_use_pred;
  assign unused_use_pred = use_pred;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_f = '0;
  logic        instr_valid_f = 1'b0;
  logic        predict_taken_f = 1'b0;
  logic [31:0] branch_target_f = '0;
  logic        stall_d = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] redirect_pc_e = '0;
  logic [31:0] PC_f, instr_d, PC_d, PCPlus4_d;
  logic        predict_taken_d, valid_d;
`ifdef BRANCH_STATS_EN
  logic [31:0] predict_cnt, redirect_cnt;
`endif

  fetch_pc_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .instr_f         (instr_f),
    .instr_valid_f   (instr_valid_f),
    .predict_taken_f (predict_taken_f),
    .branch_target_f (branch_target_f),
    .stall_d         (stall_d),
    .redirect_e      (redirect_e),
    .redirect_pc_e   (redirect_pc_e),
    .PC_f            (PC_f),
    .instr_d         (instr_d),
    .PC_d            (PC_d),
    .PCPlus4_d       (PCPlus4_d),
    .predict_taken_d (predict_taken_d),
`ifdef BRANCH_STATS_EN
    .predict_cnt     (predict_cnt),
    .redirect_cnt    (redirect_cnt),
`endif
    .valid_d         (valid_d)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what the fetch and decode stages must hold.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_pred, m_valid, m_pcd_known;
  longint unsigned m_npred, m_nredir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
    m_pred = 0; m_valid = 0; m_pcd_known = 1;
    m_npred = 0; m_nredir = 0;
  endtask

  // Apply one clock edge worth of rules to the reference state.
  task automatic model_edge();
    logic [31:0] npc;
    if (redirect_e) npc = redirect_pc_e;
    else if (stall_d || !instr_valid_f) npc = m_pc;
    else if (predict_taken_f) begin npc = branch_target_f; m_npred++; end
    else npc = m_pc + 32'd4;
    if (redirect_e) m_nredir++;

    if (redirect_e) begin
      m_instr = NOP; m_valid = 0; m_pred = 0; m_pcd = 0; m_pc4 = 0; m_pcd_known = 1;
    end else if (stall_d) begin
      // frozen
    end else if (!instr_valid_f) begin
      m_instr = NOP; m_valid = 0; m_pred = 0; m_pcd_known = 0;
    end else begin
      m_instr = instr_f; m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
      m_pred = predict_taken_f; m_valid = 1; m_pcd_known = 1;
    end
    m_pc = npc;
  endtask

  task automatic compare_all();
    chk("PC_f", PC_f, m_pc);
    chk("instr_d", instr_d, m_instr);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    chk("predict_taken_d", {31'b0, predict_taken_d}, {31'b0, m_pred});
    if (m_pcd_known) begin
      chk("PC_d", PC_d, m_pcd);
      chk("PCPlus4_d", PCPlus4_d, m_pc4);
    end
`ifdef BRANCH_STATS_EN
    chk("predict_cnt", predict_cnt, (m_npred > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_npred[31:0]);
    chk("redirect_cnt", redirect_cnt, (m_nredir > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_nredir[31:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic p, input logic [31:0] t,
                       input logic s, input logic r, input logic [31:0] rp);
    instr_valid_f = v; predict_taken_f = p; branch_target_f = t;
    stall_d = s; redirect_e = r; redirect_pc_e = rp;
    instr_f = $urandom;
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1 model_reset();
    compare_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0);
    pulse_reset();
    chk("reset PC_f", PC_f, 32'h0);
    chk("reset valid_d", {31'b0, valid_d}, 32'h0);
    chk("reset instr_d", instr_d, NOP);

    // Sequential run 0,4,8,C
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      chk("seq PC_f", PC_f, 32'(4 * i));
      chk("seq PC_d lags", PC_d, 32'(4 * (i - 1)));
      chk("seq valid_d", {31'b0, valid_d}, 32'h1);
    end

    // Predicted-taken at 0x40 -> 0x20
    drive(1, 0, 0, 0, 1, 32'h40); step();
    drive(1, 1, 32'h20, 0, 0, 0); instr_f = 32'hDEAD_0040; step();
    chk("pred PC_f", PC_f, 32'h20);
    chk("pred instr_d", instr_d, 32'hDEAD_0040);
    chk("pred PC_d", PC_d, 32'h40);
    chk("pred PCPlus4_d", PCPlus4_d, 32'h44);
    chk("pred predict_taken_d", {31'b0, predict_taken_d}, 32'h1);

    // Three miss cycles at 0x100, predictions ignored
    drive(1, 0, 0, 0, 1, 32'h100); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h500, 0, 0, 0); step();
      chk("miss PC_f", PC_f, 32'h100);
      chk("miss valid_d", {31'b0, valid_d}, 32'h0);
      chk("miss instr_d", instr_d, NOP);
    end
    drive(1, 0, 0, 0, 0, 0); step();
    chk("miss resume PC_f", PC_f, 32'h104);

    // Stall two cycles with PC_d = 0x80
    drive(1, 0, 0, 0, 1, 32'h80); step();
    drive(1, 0, 0, 0, 0, 0); instr_f = 32'hABCD_0080; step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h900, 1, 0, 0); step();
      chk("stall PC_f", PC_f, 32'h84);
      chk("stall PC_d", PC_d, 32'h80);
      chk("stall instr_d", instr_d, 32'hABCD_0080);
    end
    drive(1, 0, 0, 0, 0, 0); step();
    chk("stall release PC_f", PC_f, 32'h88);
    chk("stall release PC_d", PC_d, 32'h84);

    // Redirect beats stall and prediction
    drive(1, 1, 32'h300, 1, 1, 32'h200); step();
    chk("redir PC_f", PC_f, 32'h200);
    chk("redir valid_d", {31'b0, valid_d}, 32'h0);
    chk("redir instr_d", instr_d, NOP);
    chk("redir PC_d", PC_d, 32'h0);

    // Wrap at the top of the address space
    drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC); step();
    drive(1, 0, 0, 0, 0, 0); step();
    chk("wrap PC_f", PC_f, 32'h0);
    chk("wrap PC_d", PC_d, 32'hFFFF_FFFC);
    chk("wrap PCPlus4_d", PCPlus4_d, 32'h0);

`ifdef BRANCH_STATS_EN
    pulse_reset();
    drive(1, 0, 0, 0, 1, 32'h10); step();
    drive(1, 0, 0, 1, 1, 32'h20); step();
    chk("two redirects", redirect_cnt, 32'd2);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3), $urandom & ~32'h3,
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0), $urandom & ~32'h3);
      if (n % 700 == 699) pulse_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Fetch-stage PC generator and F/D pipeline register for the pipelined-plus-cache core. Each cycle it selects the next fetch PC from four sources, in priority order: execute-stage redirect, stall/hold, static-predictor target, PC+4. It registers the fetched instruction, PC and prediction bit into decode. It also flushes decode on a redirect and inserts bubbles on instruction-cache misses.

Parameters:
DATA_WIDTH, 32, width of PC and instruction datapath
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in decode on reset/flush (addi x0,x0,0)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
instr_f  input  DATA_WIDTH  instruction word from I-cache (RD) at PC_f
instr_valid_f  input  1  I-cache hit; instr_f valid this cycle
predict_taken_f  input  1  static predictor: branch at PC_f predicted taken
branch_target_f  input  DATA_WIDTH  static predictor target for instruction at PC_f
stall_d  input  1  hazard unit: hold decode register and PC
redirect_e  input  1  execute resolved mispredict / JALR / JAL-not-predicted; refetch
redirect_pc_e  input  DATA_WIDTH  correct next PC from execute
PC_f  output  DATA_WIDTH  current fetch address (to I-cache and predictor)
instr_d  output  DATA_WIDTH  registered instruction to decode
PC_d  output  DATA_WIDTH  registered PC of instr_d
PCPlus4_d  output  DATA_WIDTH  PC_d + 4
predict_taken_d  output  1  prediction carried to execute for resolution
valid_d  output  1  instr_d is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst=1): PC_f=RESET_PC; instr_d=NOP_INSTR; PC_d=0; PCPlus4_d=0; predict_taken_d=0; valid_d=0. Registers update on the rising clk edge once rst deasserts.
- Next-PC priority, evaluated each cycle:
  1. redirect_e=1 → PC_f <= redirect_pc_e. This applies regardless of stall_d or instr_valid_f.
  2. else stall_d=1 or instr_valid_f=0 → PC_f holds.
  3. else predict_taken_f=1 → PC_f <= branch_target_f.
  4. else PC_f <= PC_f + 4. Mod-2^DATA_WIDTH arithmetic; carry discarded; 0xFFFF_FFFC wraps to 0.
- predict_taken_f is honoured only when instr_valid_f=1. A miss-cycle prediction is ignored.
- F/D register priority:
  1. redirect_e=1 → flush: instr_d=NOP_INSTR, valid_d=0, predict_taken_d=0. PC_d and PCPlus4_d are don't-care but driven 0. Flush beats stall_d.
  2. else stall_d=1 → all D outputs hold.
  3. else instr_valid_f=0 → bubble: valid_d=0, instr_d=NOP_INSTR, predict_taken_d=0.
  4. else capture: instr_d=instr_f, PC_d=PC_f, PCPlus4_d=PC_f+4, predict_taken_d=predict_taken_f, valid_d=1.
- Latency: an instruction fetched at PC_f in cycle N appears on instr_d in cycle N+1.
  - Predicted-taken target is fetched in N+1, so there is no bubble on a correct taken prediction.
  - Redirect costs the flushed slot(s); the first refetched instruction reaches D two cycles after redirect_e.
- No internal FSM beyond the PC and D registers. PC_f low two bits pass through unmodified; alignment is the upstream unit's responsibility.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds outputs predict_cnt (32b) and redirect_cnt (32b), both saturating at 0xFFFF_FFFF and reset to 0.
  - predict_cnt increments on each cycle where rule 3 of next-PC selection fires.
  - redirect_cnt increments on each redirect_e cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then run, with rst pulsed mid-cycle, instr_valid_f=1, no predictions → PC_f immediately 0; then 0,4,8,C on successive cycles; valid_d=0 first cycle, then 1 with PC_d lagging PC_f by one.
- PC_f=0x40, predict_taken_f=1, branch_target_f=0x20 → next PC_f=0x20; instr_d=instr_f(0x40), predict_taken_d=1.
- instr_valid_f=0 for 3 cycles at PC_f=0x100 → PC_f holds 0x100; valid_d=0 and instr_d=0x13 for 3 cycles; then resumes to 0x104.
- stall_d=1 for 2 cycles with PC_d=0x80 → PC_f and all D outputs frozen; release → normal advance.
- redirect_e=1, redirect_pc_e=0x200, simultaneous with stall_d=1 and predict_taken_f=1 → PC_f=0x200 next cycle; valid_d=0, instr_d=0x13.
- PC_f=0xFFFF_FFFC, no predict → wraps to 0x0; with BRANCH_STATS_EN, 2 redirects give redirect_cnt=2, and a counter preloaded near max saturates at 0xFFFF_FFFF.
